// File: rtl/freq_meter.sv
// freq_meter: counts synchronised rising edges of sig_in over a fixed
// gate window of clk_50M cycles and latches the count once per window.
module freq_meter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int GATE_W      = 26,
  parameter int CNT_W       = 26
) (
  input  logic             clk_50M,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_out,
  output logic             freq_valid,
  output logic             overflow,
  output logic             no_signal
);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  localparam logic [GATE_W-1:0] LP_LAST =
    GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_MAX = '1;

  state_t r_state;
  state_t w_state_nxt;

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic w_rise;

  logic [GATE_W-1:0] r_gate;
  logic [GATE_W-1:0] w_gate_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              r_sat;
  logic              w_sat_nxt;
  logic              w_sat_inc;
  logic              w_term;
  logic              w_report;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_s3;
  assign w_term = (r_state == MEASURE) &&
                  (r_gate == LP_LAST);

  // Count including this cycle's rise; feeds both the
  // running counter and the end-of-window report.
  always_comb begin
    w_cnt_inc = r_cnt;
    w_sat_inc = r_sat;
    if (w_rise) begin
      if (r_cnt == LP_MAX) begin
        w_sat_inc = 1'b1;
      end else begin
        w_cnt_inc = r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gate_nxt  = '0;
    w_cnt_nxt   = '0;
    w_sat_nxt   = 1'b0;
    w_report    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (en) begin
          w_state_nxt = MEASURE;
        end
      end
      MEASURE: begin
        if (w_term) begin
          w_report = 1'b1;
          if (!en) begin
            w_state_nxt = IDLE;
          end
        end else if (!en) begin
          w_state_nxt = IDLE;
        end else begin
          w_gate_nxt = r_gate + 1'b1;
          w_cnt_nxt  = w_cnt_inc;
          w_sat_nxt  = w_sat_inc;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gate  <= '0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gate  <= w_gate_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sat   <= w_sat_nxt;
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      freq_out   <= '0;
      freq_valid <= 1'b0;
      overflow   <= 1'b0;
      no_signal  <= 1'b0;
    end else begin
      freq_valid <= w_report;
      if (w_report) begin
        freq_out  <= w_cnt_inc;
        overflow  <= w_sat_inc;
        no_signal <= (w_cnt_inc == '0);
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed stimulus with an expected-report queue,
// checked by immediate assertions on two parameterisations.
`timescale 1ns/1ps
module tb_freq_meter;

  localparam int G = 100;

  logic        clk_50M;
  logic        rst_n;
  logic        en;
  logic        sig_in;
  logic [25:0] fo;
  logic        fv;
  logic        ov;
  logic        ns;
  logic [2:0]  fo3;
  logic        fv3;
  logic        ov3;
  logic        ns3;

  typedef struct {
    bit sat;
    int cnt;
    bit ovf;
    bit nos;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   per;
  bit   lvl;
  int   ph;
  bit   bad;

  freq_meter #(
    .GATE_CYCLES(G),
    .GATE_W(26),
    .CNT_W(26)
  ) u_dut (
    .clk_50M(clk_50M),
    .rst_n(rst_n),
    .en(en),
    .sig_in(sig_in),
    .freq_out(fo),
    .freq_valid(fv),
    .overflow(ov),
    .no_signal(ns)
  );

  freq_meter #(
    .GATE_CYCLES(G),
    .GATE_W(26),
    .CNT_W(3)
  ) u_sat (
    .clk_50M(clk_50M),
    .rst_n(rst_n),
    .en(en),
    .sig_in(sig_in),
    .freq_out(fo3),
    .freq_valid(fv3),
    .overflow(ov3),
    .no_signal(ns3)
  );

  initial begin
    clk_50M = 1'b0;
    forever #10 clk_50M = ~clk_50M;
  end

  initial begin
    sig_in = 1'b0;
    ph = 0;
    forever begin
      @(negedge clk_50M);
      if (per == 0) begin
        sig_in = lvl;
        ph = 0;
      end else begin
        sig_in = (ph < per / 2);
        ph = (ph + 1 >= per) ? 0 : ph + 1;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic wait_rep(input int n, input bit sat,
                          input string tag);
    int at;
    at = 0;
    for (int i = 1; i <= n + 5; i++) begin
      @(negedge clk_50M);
      if (sat ? fv3 : fv) begin
        at = i;
        break;
      end
    end
    chk({tag, "_timing"}, at, n);
  endtask

  task automatic push(input bit sat, input int cnt,
                      input bit ovf, input bit nos);
    exp_t e;
    e.sat = sat;
    e.cnt = cnt;
    e.ovf = ovf;
    e.nos = nos;
    q.push_back(e);
  endtask

  task automatic chk_sb(input string tag);
    exp_t e;
    chk({tag, "_sb_pending"}, 32'(q.size() != 0), 1);
    if (q.size() != 0) begin
      e = q.pop_front();
      if (e.sat) begin
        chk({tag, "_freq"}, 32'(fo3), e.cnt);
        chk({tag, "_ovf"}, 32'(ov3), 32'(e.ovf));
        chk({tag, "_nosig"}, 32'(ns3), 32'(e.nos));
      end else begin
        chk({tag, "_freq"}, 32'(fo), e.cnt);
        chk({tag, "_ovf"}, 32'(ov), 32'(e.ovf));
        chk({tag, "_nosig"}, 32'(ns), 32'(e.nos));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    per   = 10;
    lvl   = 1'b0;
    repeat (5) @(negedge clk_50M);
    chk("rst_freq", 32'(fo), 0);
    chk("rst_valid", 32'(fv), 0);
    chk("rst_ovf", 32'(ov), 0);
    chk("rst_nosig", 32'(ns), 0);
    rst_n = 1'b1;

    bad = 1'b0;
    repeat (500) begin
      @(negedge clk_50M);
      if (fv || ov || ns || fo != 0) bad = 1'b1;
    end
    chk("idle_quiet", 32'(bad), 0);

    en = 1'b1;
    push(0, 10, 0, 0);
    push(0, 10, 0, 0);
    push(0, 10, 0, 0);
    wait_rep(G + 1, 0, "basic0");
    chk_sb("basic0");
    wait_rep(G, 0, "basic1");
    chk_sb("basic1");
    wait_rep(G, 0, "basic2");
    chk_sb("basic2");

    per = 0;
    lvl = 1'b1;
    wait_rep(G, 0, "nosig_settle");
    push(0, 0, 0, 1);
    push(0, 0, 0, 1);
    wait_rep(G, 0, "nosig0");
    chk_sb("nosig0");
    wait_rep(G, 0, "nosig1");
    chk_sb("nosig1");

    per = 20;
    wait_rep(G, 0, "p20_settle");
    push(0, 5, 0, 0);
    wait_rep(G, 0, "p20");
    chk_sb("p20");

    per = 4;
    wait_rep(G, 1, "sat_settle");
    push(1, 7, 1, 0);
    wait_rep(G, 1, "sat");
    chk_sb("sat");

    per = 25;
    wait_rep(G, 1, "p25_settle");
    push(1, 4, 0, 0);
    wait_rep(G, 1, "p25");
    chk_sb("p25");

    per = 10;
    wait_rep(G, 0, "p10_settle");
    push(0, 10, 0, 0);
    wait_rep(G, 0, "p10");
    chk_sb("p10");

    repeat (50) @(negedge clk_50M);
    en = 1'b0;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk_50M);
      if (fv) bad = 1'b1;
    end
    chk("abort_novalid", 32'(bad), 0);
    chk("abort_hold", 32'(fo), 10);
    en = 1'b1;
    push(0, 10, 0, 0);
    wait_rep(G + 1, 0, "abort_reentry");
    chk_sb("abort_reentry");

    repeat (70) @(negedge clk_50M);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_freq", 32'(fo), 0);
    chk("arst_valid", 32'(fv), 0);
    chk("arst_ovf", 32'(ov), 0);
    chk("arst_nosig", 32'(ns), 0);
    #2 rst_n = 1'b1;
    wait_rep(G + 1, 0, "arst_first");
    push(0, 10, 0, 0);
    wait_rep(G, 0, "arst_next");
    chk_sb("arst_next");

    chk("sb_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
